// File: rtl/i2c_fifo_pkg.sv
// Shared constants for the I2C receive FIFO and the register-interface block.
package i2c_fifo_pkg;

  function automatic int fifo_depth(input int addrsize);
    return 32'sd1 << addrsize;
  endfunction

  function automatic int fifo_cnt_w(input int addrsize);
    return addrsize + 32'sd1;
  endfunction

  localparam int FIFO_DATASIZE = 8;
  localparam int FIFO_ADDRSIZE = 4;
  localparam int FIFO_DEPTH    = fifo_depth(FIFO_ADDRSIZE);
  localparam int FIFO_CNT_W    = fifo_cnt_w(FIFO_ADDRSIZE);

endpackage

// File: rtl/fifo_ram_2p.sv
// DEPTH x DATASIZE storage: synchronous write port, combinational read port.
module fifo_ram_2p
  import i2c_fifo_pkg::*;
#(
  parameter int DATASIZE = FIFO_DATASIZE,
  parameter int ADDRSIZE = FIFO_ADDRSIZE
) (
  input  logic                clk_i,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDRSIZE);

  logic [DATASIZE-1:0] mem_r [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_rx.sv
// Show-ahead receive FIFO with flush, occupancy count and almost-full/empty flags.
// Define SYNC_FIFO_RX_ERR_EN to add sticky overflow_o/underflow_o outputs.
module sync_fifo_rx
  import i2c_fifo_pkg::*;
#(
  parameter int DATASIZE = FIFO_DATASIZE,
  parameter int ADDRSIZE = FIFO_ADDRSIZE,
  parameter int AF_LEVEL = fifo_depth(ADDRSIZE) - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                wr_en_i,
  input  logic [DATASIZE-1:0] wdata_i,
  input  logic                rd_en_i,
  output logic [DATASIZE-1:0] rdata_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                almost_full_o,
  output logic                almost_empty_o,
  output logic [ADDRSIZE:0]   count_o
`ifdef SYNC_FIFO_RX_ERR_EN
  ,
  output logic                overflow_o,
  output logic                underflow_o
`endif
);

  localparam int CNT_W = fifo_cnt_w(ADDRSIZE);
  localparam logic [CNT_W-1:0] PTR_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] PTR_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(fifo_depth(ADDRSIZE));
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_LEVEL);

  logic [CNT_W-1:0] wptr_r, rptr_r, cnt_r;
  logic [CNT_W-1:0] wptr_nxt_s, rptr_nxt_s, cnt_nxt_s;
  logic             full_r, empty_r, afull_r, aempty_r;
  logic             push_s, pop_s, we_s;

  // Accept decisions use the registered flags; flush overrides both requests.
  always_comb begin
    push_s     = wr_en_i && !full_r;
    pop_s      = rd_en_i && !empty_r;
    wptr_nxt_s = wptr_r;
    rptr_nxt_s = rptr_r;
    if (flush_i) begin
      wptr_nxt_s = PTR_ZERO;
      rptr_nxt_s = PTR_ZERO;
    end else begin
      if (push_s) begin
        wptr_nxt_s = wptr_r + PTR_ONE;
      end else begin
        wptr_nxt_s = wptr_r;
      end
      if (pop_s) begin
        rptr_nxt_s = rptr_r + PTR_ONE;
      end else begin
        rptr_nxt_s = rptr_r;
      end
    end
    // The wrap bit makes the modular difference span 0..DEPTH exactly.
    cnt_nxt_s = wptr_nxt_s - rptr_nxt_s;
    we_s      = push_s && !flush_i && rst_ni;
  end

  // Pointer, count and flag registers; flags track the next count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_r   <= PTR_ZERO;
      rptr_r   <= PTR_ZERO;
      cnt_r    <= PTR_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
    end else begin
      wptr_r   <= wptr_nxt_s;
      rptr_r   <= rptr_nxt_s;
      cnt_r    <= cnt_nxt_s;
      full_r   <= (cnt_nxt_s == DEPTH_C);
      empty_r  <= (cnt_nxt_s == PTR_ZERO);
      afull_r  <= (cnt_nxt_s >= AF_C);
      aempty_r <= (cnt_nxt_s <= AE_C);
    end
  end

  fifo_ram_2p #(
    .DATASIZE(DATASIZE),
    .ADDRSIZE(ADDRSIZE)
  ) u_ram (
    .clk_i(clk_i),
    .we   (we_s),
    .waddr(wptr_r[ADDRSIZE-1:0]),
    .wdata(wdata_i),
    .raddr(rptr_r[ADDRSIZE-1:0]),
    .rdata(rdata_o)
  );

  assign full_o         = full_r;
  assign empty_o        = empty_r;
  assign almost_full_o  = afull_r;
  assign almost_empty_o = aempty_r;
  assign count_o        = cnt_r;

`ifdef SYNC_FIFO_RX_ERR_EN
  logic ovf_r, unf_r;

  // Sticky error flags for requests rejected by the full/empty guards.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (flush_i) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r || (wr_en_i && full_r);
      unf_r <= unf_r || (rd_en_i && empty_r);
    end
  end

  assign overflow_o  = ovf_r;
  assign underflow_o = unf_r;
`endif

endmodule

// File: tb/tb_sync_fifo_rx.sv
// Directed self-checking bench for sync_fifo_rx (default parameters).
module tb_sync_fifo_rx;

  logic       clk_i = 1'b0;
  logic       rst_ni, flush_i, wr_en_i, rd_en_i;
  logic [7:0] wdata_i, rdata_o;
  logic       full_o, empty_o, almost_full_o, almost_empty_o;
  logic [4:0] count_o;
`ifdef SYNC_FIFO_RX_ERR_EN
  logic       overflow_o, underflow_o;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  sync_fifo_rx dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .wr_en_i(wr_en_i), .wdata_i(wdata_i), .rd_en_i(rd_en_i),
    .rdata_o(rdata_o), .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .count_o(count_o)
`ifdef SYNC_FIFO_RX_ERR_EN
    , .overflow_o(overflow_o), .underflow_o(underflow_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0; wdata_i = 8'h00;
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    chk_cnt++; if (empty_o !== 1'b1) $display("FAIL reset_empty got %b want 1", empty_o); else pass_cnt++;
    chk_cnt++; if (full_o !== 1'b0) $display("FAIL reset_full got %b want 0", full_o); else pass_cnt++;
    chk_cnt++; if (count_o !== 5'd0) $display("FAIL reset_count got %0d want 0", count_o); else pass_cnt++;
    chk_cnt++; if (almost_empty_o !== 1'b1) $display("FAIL reset_ae got %b want 1", almost_empty_o); else pass_cnt++;
    chk_cnt++; if (almost_full_o !== 1'b0) $display("FAIL reset_af got %b want 0", almost_full_o); else pass_cnt++;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      wr_en_i = 1'b1; wdata_i = 8'(i);
      tick();
      chk_cnt++; if (count_o !== 5'(i)) $display("FAIL fill_count got %0d want %0d", count_o, i); else pass_cnt++;
      chk_cnt++; if (almost_full_o !== (i >= 14)) $display("FAIL fill_af at %0d got %b", i, almost_full_o); else pass_cnt++;
      chk_cnt++; if (almost_empty_o !== (i <= 1)) $display("FAIL fill_ae at %0d got %b", i, almost_empty_o); else pass_cnt++;
    end
    wr_en_i = 1'b0;
    chk_cnt++; if (full_o !== 1'b1) $display("FAIL fill_full got %b want 1", full_o); else pass_cnt++;
    for (int i = 1; i <= 16; i++) begin
      rd_en_i = 1'b1;
      chk_cnt++; if (rdata_o !== 8'(i)) $display("FAIL drain_data got %h want %h", rdata_o, 8'(i)); else pass_cnt++;
      tick();
      chk_cnt++; if (count_o !== 5'(16 - i)) $display("FAIL drain_count got %0d want %0d", count_o, 16 - i); else pass_cnt++;
    end
    rd_en_i = 1'b0;
    chk_cnt++; if (empty_o !== 1'b1) $display("FAIL drain_empty got %b want 1", empty_o); else pass_cnt++;
    chk_cnt++; if (full_o !== 1'b0) $display("FAIL drain_full got %b want 0", full_o); else pass_cnt++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) begin
      wr_en_i = 1'b1; wdata_i = 8'(8'h21 + i);
      tick();
    end
    wdata_i = 8'hAA;
    tick();
    wr_en_i = 1'b0;
    chk_cnt++; if (count_o !== 5'd16) $display("FAIL ovf_count got %0d want 16", count_o); else pass_cnt++;
    chk_cnt++; if (full_o !== 1'b1) $display("FAIL ovf_full got %b want 1", full_o); else pass_cnt++;
`ifdef SYNC_FIFO_RX_ERR_EN
    chk_cnt++; if (overflow_o !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow_o); else pass_cnt++;
`endif
    for (int i = 0; i < 16; i++) begin
      rd_en_i = 1'b1;
      chk_cnt++; if (rdata_o !== 8'(8'h21 + i)) $display("FAIL ovf_drain got %h want %h", rdata_o, 8'(8'h21 + i)); else pass_cnt++;
      tick();
    end
    // One extra pop on empty must be ignored.
    tick();
    rd_en_i = 1'b0;
    chk_cnt++; if (count_o !== 5'd0) $display("FAIL unf_count got %0d want 0", count_o); else pass_cnt++;
    chk_cnt++; if (empty_o !== 1'b1) $display("FAIL unf_empty got %b want 1", empty_o); else pass_cnt++;
`ifdef SYNC_FIFO_RX_ERR_EN
    chk_cnt++; if (overflow_o !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow_o); else pass_cnt++;
    chk_cnt++; if (underflow_o !== 1'b1) $display("FAIL unf_flag got %b want 1", underflow_o); else pass_cnt++;
`endif
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
`ifdef SYNC_FIFO_RX_ERR_EN
    chk_cnt++; if (overflow_o !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow_o); else pass_cnt++;
    chk_cnt++; if (underflow_o !== 1'b0) $display("FAIL unf_clear got %b want 0", underflow_o); else pass_cnt++;
`endif
  endtask

  task automatic test_simultaneous();
    wr_en_i = 1'b1; rd_en_i = 1'b1; wdata_i = 8'h5C;
    tick();
    rd_en_i = 1'b0;
    chk_cnt++; if (count_o !== 5'd1) $display("FAIL simul_empty_count got %0d want 1", count_o); else pass_cnt++;
    chk_cnt++; if (rdata_o !== 8'h5C) $display("FAIL simul_empty_data got %h want 5c", rdata_o); else pass_cnt++;
    chk_cnt++; if (empty_o !== 1'b0) $display("FAIL simul_empty_flag got %b want 0", empty_o); else pass_cnt++;
    for (int i = 1; i <= 15; i++) begin
      wdata_i = 8'(8'h60 + i);
      tick();
    end
    chk_cnt++; if (full_o !== 1'b1) $display("FAIL simul_prefull got %b want 1", full_o); else pass_cnt++;
    rd_en_i = 1'b1; wdata_i = 8'h77;
    tick();
    wr_en_i = 1'b0; rd_en_i = 1'b0;
    chk_cnt++; if (count_o !== 5'd15) $display("FAIL simul_full_count got %0d want 15", count_o); else pass_cnt++;
    chk_cnt++; if (full_o !== 1'b0) $display("FAIL simul_full_flag got %b want 0", full_o); else pass_cnt++;
    chk_cnt++; if (rdata_o !== 8'h61) $display("FAIL simul_full_head got %h want 61", rdata_o); else pass_cnt++;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic test_wrap();
    int w, r;
    // Advance both pointers to 10 so the run crosses the address wrap.
    for (int i = 0; i < 10; i++) begin
      wr_en_i = 1'b1; wdata_i = 8'hFF;
      tick();
    end
    wr_en_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd_en_i = 1'b1;
      tick();
    end
    rd_en_i = 1'b0;
    w = 0; r = 0;
    for (int cyc = 0; cyc < 23; cyc++) begin
      wr_en_i = (w < 20);
      rd_en_i = (cyc >= 3) && (r < 20);
      wdata_i = 8'(8'h80 + w);
      if (rd_en_i) begin
        chk_cnt++; if (rdata_o !== 8'(8'h80 + r)) $display("FAIL wrap_data got %h want %h", rdata_o, 8'(8'h80 + r)); else pass_cnt++;
      end
      tick();
      if (wr_en_i) w++;
      if (rd_en_i) r++;
      chk_cnt++; if (count_o !== 5'(w - r)) $display("FAIL wrap_count got %0d want %0d", count_o, w - r); else pass_cnt++;
    end
    wr_en_i = 1'b0; rd_en_i = 1'b0;
    chk_cnt++; if (empty_o !== 1'b1) $display("FAIL wrap_empty got %b want 1", empty_o); else pass_cnt++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) begin
      wr_en_i = 1'b1; wdata_i = 8'(8'h40 + i);
      tick();
    end
    chk_cnt++; if (count_o !== 5'd7) $display("FAIL flush_pre_count got %0d want 7", count_o); else pass_cnt++;
    flush_i = 1'b1; wdata_i = 8'hEE;
    tick();
    flush_i = 1'b0;
    chk_cnt++; if (count_o !== 5'd0) $display("FAIL flush_count got %0d want 0", count_o); else pass_cnt++;
    chk_cnt++; if (empty_o !== 1'b1) $display("FAIL flush_empty got %b want 1", empty_o); else pass_cnt++;
    chk_cnt++; if (almost_empty_o !== 1'b1) $display("FAIL flush_ae got %b want 1", almost_empty_o); else pass_cnt++;
    wdata_i = 8'h33;
    tick();
    wr_en_i = 1'b0;
    chk_cnt++; if (rdata_o !== 8'h33) $display("FAIL flush_next_data got %h want 33", rdata_o); else pass_cnt++;
    chk_cnt++; if (count_o !== 5'd1) $display("FAIL flush_next_count got %0d want 1", count_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    wr_en_i = 1'b1; wdata_i = 8'h99;
    tick(); tick();
    chk_cnt++; if (count_o !== 5'd3) $display("FAIL mid_pre_count got %0d want 3", count_o); else pass_cnt++;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1; wr_en_i = 1'b0;
    chk_cnt++; if (count_o !== 5'd0) $display("FAIL mid_reset_count got %0d want 0", count_o); else pass_cnt++;
    chk_cnt++; if (empty_o !== 1'b1) $display("FAIL mid_reset_empty got %b want 1", empty_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_simultaneous();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
